// File: rtl/display_pkg.sv
// Shared character codes, buffer entry layout and code helpers for the display path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package display_pkg;

  // Character code understood by the 7-segment decoder
  typedef logic [5:0] char_t;

  localparam char_t CH_BLANK = 6'd0;
  localparam char_t CH_0     = 6'd1;
  localparam char_t CH_1     = 6'd2;
  localparam char_t CH_2     = 6'd3;
  localparam char_t CH_3     = 6'd4;
  localparam char_t CH_4     = 6'd5;
  localparam char_t CH_5     = 6'd6;
  localparam char_t CH_6     = 6'd7;
  localparam char_t CH_7     = 6'd8;
  localparam char_t CH_8     = 6'd9;
  localparam char_t CH_9     = 6'd10;
  localparam char_t CH_A     = 6'd11;
  localparam char_t CH_DASH  = 6'd38;
  localparam char_t CH_MAX   = 6'd38;

  // One character buffer slot: decimal point plus character code
  typedef struct packed {
    logic  dot;
    char_t code;
  } entry_t;

  // Decimal digit 0..9 to its character code; anything else shows blank
  function automatic char_t encode_digit(input logic [3:0] value);
    if (value > 4'd9) begin
      return CH_BLANK;
    end
    return char_t'({2'b00, value} + 6'd1);
  endfunction

  // Codes the decoder does not know are stored as blank
  function automatic char_t sanitize_char(input char_t code);
    return (code > CH_MAX) ? CH_BLANK : code;
  endfunction

endpackage

// File: rtl/display_pwm.sv
// Brightness PWM: free-running counter compared against a duty setting, all-ones duty = always on.
// Latency: light is registered, one cycle after the counter/duty values it is derived from.
// Backpressure: none; duty may change any cycle and takes effect on the next compare.
module display_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                light
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                full_on;

  // All-ones duty must never drop out for the single count where cnt == duty
  assign full_on = &duty;

  // Free-running counter and registered light gate
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_cnt <= '0;
      light   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      light   <= full_on || (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed display scanner: DIGITS-entry character buffer scanned onto a 7-seg decoder, blink via DISPLAY_BLINK_EN.
// Latency: number/dot/ena/light one cycle after the scan index, digit_sel two cycles (matches registered decoder).
// Backpressure: none; writes always accepted, out-of-range addresses and unknown codes are dropped/blanked.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
`ifdef DISPLAY_BLINK_EN
  parameter int BLINK_FRAMES = 64,
`endif
  parameter int PWM_BITS     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DIGITS)-1:0]  wr_addr,
  input  logic [5:0]                 wr_char,
  input  logic                       wr_dot,
`ifdef DISPLAY_BLINK_EN
  input  logic                       wr_blink,
`endif
  input  logic [PWM_BITS-1:0]        brightness,
  input  logic                       enable,
  output logic [5:0]                 number,
  output logic                       dot,
  output logic                       ena,
  output logic                       light,
  output logic [DIGITS-1:0]          digit_sel,
  output logic                       frame_tick
);

  localparam int              AW       = $clog2(DIGITS);
  localparam int              PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRE_TC   = PW'(SCAN_DIV - 1);
  localparam logic [AW-1:0]   IDX_LAST = AW'(DIGITS - 1);
  localparam logic [AW:0]     DIGITS_W = (AW + 1)'(DIGITS);

  entry_t            char_buf [DIGITS];
  logic [PW-1:0]     pre;
  logic [AW-1:0]     idx;
  logic              slot_first;
  logic              slot_end;
  logic              frame_wrap;
  logic              wr_ok;
  logic              blink_hide;
  entry_t            cur;
  logic [DIGITS-1:0] sel_next;
  logic [DIGITS-1:0] sel_d1;

  assign slot_first = (pre == '0);
  assign slot_end   = (pre == PRE_TC);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  // Only power-of-two DIGITS can address every wr_addr value; others must be filtered
  assign wr_ok      = wr_en && ({1'b0, wr_addr} < DIGITS_W);
  assign cur        = char_buf[idx];
  assign sel_next   = enable ? (DIGITS'(1) << idx) : '0;

  // Character buffer: cleared on reset, written by system logic at any time
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        char_buf[i] <= '0;
      end
    end else if (wr_ok) begin
      char_buf[wr_addr] <= '{dot: wr_dot, code: sanitize_char(wr_char)};
    end
  end

  // Scan timing: prescaler holds each digit SCAN_DIV cycles, then advances the digit index
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (slot_end) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int            BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_FRAMES - 1);

  logic          blink_flag [DIGITS];
  logic          blink_phase;
  logic [BW-1:0] blink_cnt;

  // Per-entry blink flags, written alongside the character
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        blink_flag[i] <= 1'b0;
      end
    end else if (wr_ok) begin
      blink_flag[wr_addr] <= wr_blink;
    end
  end

  // Blink phase flips every BLINK_FRAMES completed frames, starting visible
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLINK_TC) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_hide = blink_phase && blink_flag[idx];
`else
  assign blink_hide = 1'b0;
`endif

  // Decoder feed: character registered from the current slot; ena low on the slot's first
  // cycle so the old segments never light under the new anode; anode delayed two stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      number    <= '0;
      dot       <= 1'b0;
      ena       <= 1'b0;
      sel_d1    <= '0;
      digit_sel <= '0;
    end else begin
      number    <= cur.code;
      dot       <= cur.dot;
      ena       <= enable && !slot_first && !blink_hide;
      sel_d1    <= sel_next;
      digit_sel <= sel_d1;
    end
  end

  display_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .duty  (brightness),
    .light (light)
  );

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: cycle-count model of the scan plus directed literal checks.
// Main instance DIGITS=4, SCAN_DIV=4; a DIGITS=3 instance covers out-of-range write addresses.
// With DISPLAY_BLINK_EN the main instance uses BLINK_FRAMES=2 with entry 1 blinking.
module tb_display_scanner;
  import display_pkg::*;

  localparam int D  = 4;
  localparam int SD = 4;
`ifdef DISPLAY_BLINK_EN
  localparam int BF = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_dot, wr_blink, enable;
  logic [1:0] wr_addr;
  logic [5:0] wr_char;
  logic [3:0] brightness;
  logic [5:0] number;
  logic       dot, ena, light, frame_tick;
  logic [3:0] digit_sel;

  logic       wr_en3, wr_dot3;
  logic [1:0] wr_addr3;
  logic [5:0] wr_char3;
  logic [5:0] number3;
  logic       dot3, ena3, light3, frame_tick3;
  logic [2:0] digit_sel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scanner #(
    .DIGITS       (D),
    .SCAN_DIV     (SD),
`ifdef DISPLAY_BLINK_EN
    .BLINK_FRAMES (BF),
`endif
    .PWM_BITS     (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .wr_dot     (wr_dot),
`ifdef DISPLAY_BLINK_EN
    .wr_blink   (wr_blink),
`endif
    .brightness (brightness),
    .enable     (enable),
    .number     (number),
    .dot        (dot),
    .ena        (ena),
    .light      (light),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  display_scanner #(
    .DIGITS   (3),
    .SCAN_DIV (SD),
    .PWM_BITS (4)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en3),
    .wr_addr    (wr_addr3),
    .wr_char    (wr_char3),
    .wr_dot     (wr_dot3),
`ifdef DISPLAY_BLINK_EN
    .wr_blink   (1'b0),
`endif
    .brightness (brightness),
    .enable     (enable),
    .number     (number3),
    .dot        (dot3),
    .ena        (ena3),
    .light      (light3),
    .digit_sel  (digit_sel3),
    .frame_tick (frame_tick3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // c = rising edges since reset release; the scan position after c edges is
  // slot (c / SCAN_DIV) mod DIGITS, cycle (c mod SCAN_DIV) inside it.
  entry_t     mbuf [D];
  logic       mbl  [D];
  logic       mphase;
  int         mfc;
  int         c;
  logic       model_on = 1'b0;
  logic [5:0] exp_number;
  logic       exp_dot, exp_ena, exp_ft, exp_light;
  logic [3:0] exp_sel, exp_sel1;

  always @(posedge clk) begin : model
    int pp;
    int ip;
    if (!rst) begin
      c = 0;
      for (int i = 0; i < D; i++) begin
        mbuf[i] = '0;
        mbl[i]  = 1'b0;
      end
      mphase = 1'b0; mfc = 0;
      exp_number = '0; exp_dot = 1'b0; exp_ena = 1'b0; exp_ft = 1'b0;
      exp_light = 1'b0; exp_sel = '0; exp_sel1 = '0;
      model_on = 1'b1;
    end else begin
      pp = c % SD;
      ip = (c / SD) % D;
      exp_number = mbuf[ip].code;
      exp_dot    = mbuf[ip].dot;
      exp_ena    = enable && (pp != 0) && !(mphase && mbl[ip]);
      exp_ft     = (pp == SD - 1) && (ip == D - 1);
      exp_sel    = exp_sel1;
      exp_sel1   = enable ? 4'(1 << ip) : 4'd0;
      exp_light  = (brightness == 4'd15) || ((c % 16) < int'(brightness));
`ifdef DISPLAY_BLINK_EN
      if (exp_ft) begin
        mfc++;
        if (mfc == BF) begin
          mfc = 0;
          mphase = ~mphase;
        end
      end
`endif
      if (wr_en && int'(wr_addr) < D) begin
        mbuf[wr_addr] = entry_t'({wr_dot, (wr_char > 6'd38) ? 6'd0 : wr_char});
        mbl[wr_addr]  = wr_blink;
      end
      c++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_number", number, exp_number);
      chk("m_dot", dot, exp_dot);
      chk("m_ena", ena, exp_ena);
      chk("m_frame_tick", frame_tick, exp_ft);
      chk("m_digit_sel", digit_sel, exp_sel);
      chk("m_light", light, exp_light);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int a, input int ch, input bit d, input bit bl);
    wr_en = 1'b1; wr_addr = a[1:0]; wr_char = ch[5:0]; wr_dot = d; wr_blink = bl;
    @(negedge clk);
    wr_en = 1'b0; wr_blink = 1'b0;
  endtask

  task automatic wr3(input int a, input int ch);
    wr_en3 = 1'b1; wr_addr3 = a[1:0]; wr_char3 = ch[5:0];
    @(negedge clk);
    wr_en3 = 1'b0;
  endtask

  task automatic wait_ft();
    bit ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_tick_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_ft3();
    bit ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (frame_tick3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_tick3_seen", 32'(ok), 32'd1);
  endtask

  task automatic count_light(input string name, input int exp);
    int lc = 0;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      lc += int'(light);
    end
    chk(name, lc, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bit seen9;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; wr_dot = 1'b0; wr_blink = 1'b0;
    enable = 1'b1; brightness = 4'd4;
    wr_en3 = 1'b0; wr_addr3 = '0; wr_char3 = '0; wr_dot3 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_number", number, 0);
    chk("rst_ena", ena, 0);
    chk("rst_light", light, 0);
    chk("rst_digit_sel", digit_sel, 0);
    chk("rst_frame_tick", frame_tick, 0);
    rst = 1'b1;

    // Buffer contents '2', '5.', '-', blank with dot; entry 1 blinks when enabled
    wr(0, 3, 1'b0, 1'b0);
    wr(1, 6, 1'b1, 1'b1);
    wr(2, 38, 1'b0, 1'b0);
    wr(3, 0, 1'b1, 1'b0);

    wait_ft();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      case (k)
        1:  begin chk("k1_ena_guard", ena, 0); chk("k1_sel_lag", digit_sel, 4'b1000); chk("k1_num", number, 3); end
        2:  begin chk("k2_num", number, 3); chk("k2_dot", dot, 0); chk("k2_ena", ena, 1); chk("k2_sel", digit_sel, 4'b0001); end
        6:  begin chk("k6_num", number, 6); chk("k6_dot", dot, 1); end
        7:  chk("k7_sel", digit_sel, 4'b0010);
        10: begin chk("k10_num", number, 38); chk("k10_dot", dot, 0); end
        11: chk("k11_sel", digit_sel, 4'b0100);
        14: begin chk("k14_num", number, 0); chk("k14_dot", dot, 1); end
        15: chk("k15_sel", digit_sel, 4'b1000);
        16: chk("frame_period_16", frame_tick, 1);
        default: ;
      endcase
    end

    // Unknown code stored as blank
    wr(2, 45, 1'b0, 1'b0);
    wait_ft();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) chk("bad_code_blank", number, 0);
    end

    // Out-of-range address on the 3-digit instance is ignored
    wr3(0, 1); wr3(1, 2); wr3(2, 3); wr3(3, 9);
    wait_ft3();
    seen9 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (number3 == 6'd9) seen9 = 1'b1;
      case (k)
        2:  chk("d3_num0", number3, 1);
        6:  chk("d3_num1", number3, 2);
        10: chk("d3_num2", number3, 3);
        12: chk("d3_frame_period_12", frame_tick3, 1);
        default: ;
      endcase
    end
    chk("d3_addr3_ignored", 32'(seen9), 0);

    // PWM duty
    brightness = 4'd4;  count_light("light_duty_4", 4);
    brightness = 4'd15; count_light("light_duty_15", 16);
    brightness = 4'd0;  count_light("light_duty_0", 0);
    brightness = 4'd9;  count_light("light_duty_9", 9);

    // Enable off mid-scan: blanks after the pipeline, scan keeps running
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_ena", ena, 0);
    chk("dis_digit_sel", digit_sel, 0);
    wait_ft();
    enable = 1'b1;
    repeat (20) @(negedge clk);

    // Reset mid-scan, then restart from digit 0 with a cleared buffer
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_number", number, 0);
    chk("mid_rst_digit_sel", digit_sel, 0);
    chk("mid_rst_ena", ena, 0);
    rst = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        n = k;
        break;
      end
    end
    chk("restart_first_tick_16", n, 16);
    repeat (4) @(negedge clk);
    chk("restart_buf_cleared", number, 0);

`ifdef DISPLAY_BLINK_EN
    // Blink phase runs for several frames; the model checks ena of digit 1 each cycle
    wr(1, 6, 1'b1, 1'b1);
    repeat (80) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
